// File: rtl/tm_axis_pkg.sv
// Shared constants for the Tsetlin inference stream datapath.
// The default buffer depth is the number of stream words needed to carry one feature vector.
package tm_axis_pkg;

  localparam int DATA_WIDTH_DEFAULT  = 64;
  localparam int FEATURE_NUM         = 784;
  localparam int PACKETS_NUM_DEFAULT = (FEATURE_NUM - 1) / DATA_WIDTH_DEFAULT + 1;

  // Width of a pointer into a buffer of the given depth (at least one bit)
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_adder_s00_axis_circ_ptr.sv
// Incrementing pointer that wraps from DEPTH-1 back to 0.
// The wrap is explicit, so the depth does not have to be a power of two.
module circ_ptr #(
  parameter int DEPTH = 13,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (inc)
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
  end

endmodule

// File: rtl/axis_adder_s00_axis.sv
// AXI4-Stream slave ingress buffer: a circular buffer with first-word-fall-through output.
// It also exports a per-slot occupancy bitmap and a full flag for the inference core.
module axis_adder_s00_axis
  import tm_axis_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEFAULT,
  parameter int PACKETS_NUM = PACKETS_NUM_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic                   s_axis_tlast,
  output logic [PACKETS_NUM-1:0] valid,
  output logic                   full,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  localparam int PW = ptr_width(PACKETS_NUM);

  logic [DATA_WIDTH-1:0] mem [PACKETS_NUM];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  push;
  logic                  pop;
  logic                  unused_tlast;

  // Framing is tracked by the inference core, so tlast is deliberately dropped here
  assign unused_tlast = s_axis_tlast;

  assign full          = &valid;
  assign s_axis_tready = !rst && !full;
  assign m_axis_tvalid = valid[rd_ptr];
  assign m_axis_tdata  = m_axis_tvalid ? mem[rd_ptr] : '0;

  assign push = s_axis_tvalid && s_axis_tready;
  assign pop  = m_axis_tvalid && m_axis_tready;

  circ_ptr #(.DEPTH(PACKETS_NUM), .WIDTH(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push),
    .ptr (wr_ptr)
  );

  circ_ptr #(.DEPTH(PACKETS_NUM), .WIDTH(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= s_axis_tdata;
  end

  // A simultaneous push and pop always touch different slots, so both updates can apply
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (push)
        valid[wr_ptr] <= 1'b1;
      if (pop)
        valid[rd_ptr] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_adder_s00_axis.sv
// Self-checking bench for axis_adder_s00_axis.
// The reference model is a word queue plus a head slot index, stepped once per clock edge.
module tb_axis_adder_s00_axis;
  import tm_axis_pkg::*;

  localparam int DW = 64;
  localparam int PN = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [PN-1:0] valid;
  logic          full;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;

  int            vectors = 0;
  int            miscompares = 0;
  logic [DW-1:0] model_q[$];
  int            model_head = 0;

  always #5 clk = ~clk;

  axis_adder_s00_axis #(.DATA_WIDTH(DW), .PACKETS_NUM(PN)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .valid         (valid),
    .full          (full),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Occupied slots are the `size` slots starting at the head, wrapping modulo the depth
  function automatic logic [PN-1:0] model_valid();
    logic [PN-1:0] v;
    v = '0;
    for (int i = 0; i < PN; i++)
      if (((i - model_head + PN) % PN) < model_q.size())
        v[i] = 1'b1;
    return v;
  endfunction

  task automatic applyStimulus(input logic v, input logic [DW-1:0] d, input logic mr, input logic r);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = 1'($urandom_range(0, 1));
    m_axis_tready = mr;
    rst           = r;
  endtask

  task automatic checkOutput();
    logic exp_full;
    exp_full = (model_q.size() == PN);
    check("full", 64'(full), 64'(exp_full));
    check("s_tready", 64'(s_axis_tready), 64'(!rst && !exp_full));
    check("m_tvalid", 64'(m_axis_tvalid), 64'(model_q.size() > 0));
    check("m_tdata", m_axis_tdata, (model_q.size() > 0) ? model_q[0] : 64'd0);
    check("valid", 64'(valid), 64'(model_valid()));
  endtask

  // One clock: drive, check before the edge, then advance the model across the edge
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic mr, input logic r);
    logic do_push;
    logic do_pop;
    applyStimulus(v, d, mr, r);
    @(negedge clk);
    checkOutput();
    do_push = v && !r && (model_q.size() < PN);
    do_pop  = mr && (model_q.size() > 0);
    @(posedge clk);
    if (r) begin
      model_q.delete();
      model_head = 0;
    end else begin
      if (do_pop) begin
        void'(model_q.pop_front());
        model_head = (model_head + 1) % PN;
      end
      if (do_push)
        model_q.push_back(d);
    end
    #1;
  endtask

  initial begin
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    $display("[TB] reset then idle");
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);

    $display("[TB] single word");
    cycle(1'b1, 64'hDEADBEEF_00000001, 1'b0, 1'b0);
    check("single_valid", 64'(valid), 64'h0001);
    check("single_data", m_axis_tdata, 64'hDEADBEEF_00000001);
    cycle(1'b0, '0, 1'b0, 1'b1);

    $display("[TB] fill");
    for (int i = 1; i <= PN; i++)
      cycle(1'b1, 64'(i), 1'b0, 1'b0);
    check("fill_valid", 64'(valid), 64'h1FFF);
    check("fill_full", 64'(full), 64'd1);
    cycle(1'b1, 64'd14, 1'b0, 1'b0);
    cycle(1'b1, 64'd14, 1'b0, 1'b0);

    $display("[TB] drain from full");
    cycle(1'b1, 64'd14, 1'b1, 1'b0);
    check("drain_full_drop", 64'(full), 64'd0);
    for (int i = 0; i < PN + 2; i++)
      cycle(1'b0, '0, 1'b1, 1'b0);
    check("drain_empty", 64'(m_axis_tvalid), 64'd0);

    $display("[TB] wrap-around streaming");
    cycle(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++)
      cycle(1'b1, 64'(i), 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 5; i++)
      cycle(1'b1, 64'(100 + i), 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("mid_reset_valid", 64'(valid), 64'd0);
    cycle(1'b1, 64'hCAFE, 1'b0, 1'b0);
    check("post_reset_slot0", 64'(valid), 64'h0001);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [DW-1:0] d;
      d = {$urandom, $urandom};
      cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 79) == 0));
    end
    for (int i = 0; i < PN + 1; i++)
      cycle(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
